neuron_mac_acc: RTL and testbench

Streaming multiply-accumulate neuron stage that computes one pre-activation value `sum(x[i]*w[i]) + bias` in signed Q(N-Q).Q fixed point. It sits directly upstream of the tanh LUT/interpolation activation stage. It accepts input/weight pairs over a valid/ready handshake and accumulates at full precision. It rounds and saturates the result back to N bits and presents it to the activation stage over a second valid/ready handshake.

---
 rtl/neuron_mac_acc_if.sv | 29 ++
 rtl/neuron_mac_acc.sv | 108 ++++++++++
 tb/tb_neuron_mac_acc.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_acc_if.sv
// Handshake bundle for the MAC neuron stage: command/operand stream in,
// rounded pre-activation out toward the activation stage.
interface neuron_mac_acc_if #(
  parameter int N     = 32,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [N-1:0]     bias;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     x;
  logic [N-1:0]     w;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             sat;
  logic             busy;

  modport master (
    output start, len, bias, in_valid, x, w, out_ready,
    input  in_ready, out_valid, out_data, sat, busy
  );

  modport slave (
    input  start, len, bias, in_valid, x, w, out_ready,
    output in_ready, out_valid, out_data, sat, busy
  );
endinterface

// File: rtl/neuron_mac_acc.sv
// Streaming dot product + bias in signed Q fixed point, full-precision
// accumulation, round-half-up and saturation back to N bits.
module neuron_mac_acc #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int LEN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  neuron_mac_acc_if.slave bus
);
  localparam int AW = 2*N + LEN_W;
  localparam logic signed [AW-1:0] HALF = AW'(1) << (Q-1);

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, ROUND, OUT} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt;
  logic signed [2*N-1:0]   prod;
  logic                    prod_vld;
  logic signed [AW-1:0]    acc;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    sat_q;
  logic [N-1:0]            out_q;

  logic signed [N-1:0]     xs, ws;
  logic signed [AW-1:0]    acc_rnd, r;
  logic                    accept, sat_hi, sat_lo;

  assign xs      = bus.x;
  assign ws      = bus.w;
  assign accept  = bus.in_valid & in_ready_q;
  assign acc_rnd = acc + HALF;
  assign r       = acc_rnd >>> Q;

  // r fits in N bits only when bits [AW-1:N-1] are all copies of the sign
  assign sat_hi = ~r[AW-1] & (|r[AW-2:N-1]);
  assign sat_lo =  r[AW-1] & ~(&r[AW-2:N-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      cnt         <= '0;
      prod        <= '0;
      prod_vld    <= 1'b0;
      acc         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      out_q       <= '0;
    end else begin
      prod_vld <= 1'b0;
      if (prod_vld)
        acc <= acc + {{LEN_W{prod[2*N-1]}}, prod};

      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q      <= bus.len;
            cnt        <= '0;
            acc        <= {{(N+LEN_W-Q){bus.bias[N-1]}}, bus.bias, {Q{1'b0}}};
            in_ready_q <= (bus.len != '0);
            state      <= (bus.len != '0) ? ACC : ROUND;
          end
        end
        ACC: begin
          if (accept) begin
            prod     <= (2*N)'(xs) * (2*N)'(ws);
            prod_vld <= 1'b1;
            cnt      <= cnt + 1'b1;
            if (cnt + 1'b1 == len_q) begin
              in_ready_q <= 1'b0;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: state <= ROUND;
        ROUND: begin
          if (sat_hi)
            out_q <= {1'b0, {(N-1){1'b1}}};
          else if (sat_lo)
            out_q <= {1'b1, {(N-1){1'b0}}};
          else
            out_q <= r[N-1:0];
          sat_q       <= sat_hi | sat_lo;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.sat       = sat_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed bench for neuron_mac_acc: hand-computed dot products, latency,
// saturation, rounding, zero length, gaps/backpressure and mid-run reset.
module tb_neuron_mac_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  neuron_mac_acc_if #(.N(32), .LEN_W(8)) bus ();

  neuron_mac_acc #(.N(32), .Q(16), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] l, input logic [31:0] b);
    bus.start = 1'b1; bus.len = l; bus.bias = b;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] xv, input logic [31:0] wv, output bit to);
    bus.in_valid = 1'b1; bus.x = xv; bus.w = wv;
    for (int k = 0; k < 50 && !bus.in_ready; k++) cyc();
    to = !bus.in_ready;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n, output bit to);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      cyc();
      n++;
    end
    to = !bus.out_valid;
  endtask

  task automatic finish_out();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    n_cmp++; if (bus.sat !== 1'b0) begin n_bad++; $display("FAIL rst_sat: got %b want 0", bus.sat); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    bit t0, t1, t2;
    int n;
    start_op(8'd2, 32'h0001_0000);
    feed(32'h0001_8000, 32'h0002_0000, t0);
    feed(32'hFFFF_8000, 32'h0002_0000, t1);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_after_len: got %b want 0", bus.in_ready); end
    wait_out(n, t2);
    n_cmp++; if (t0 || t1 || t2) begin n_bad++; $display("FAIL basic_timeout: got %b%b%b want 000", t0, t1, t2); end
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d want 2", n); end
    n_cmp++; if (bus.out_data !== 32'h0003_0000) begin n_bad++; $display("FAIL basic_data: got %h want 00030000", bus.out_data); end
    n_cmp++; if (bus.sat !== 1'b0) begin n_bad++; $display("FAIL basic_sat: got %b want 0", bus.sat); end
    finish_out();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_saturation();
    bit to;
    int n;
    logic [31:0] wv [2];
    logic [31:0] exp_d [2];
    wv[0] = 32'h7FFF_0000; exp_d[0] = 32'h7FFF_FFFF;
    wv[1] = 32'h8001_0000; exp_d[1] = 32'h8000_0000;
    for (int r = 0; r < 2; r++) begin
      bit any_to;
      any_to = 1'b0;
      start_op(8'd4, 32'h0);
      for (int b = 0; b < 4; b++) begin
        feed(32'h7FFF_0000, wv[r], to);
        any_to |= to;
      end
      wait_out(n, to);
      any_to |= to;
      n_cmp++; if (any_to || bus.out_data !== exp_d[r]) begin n_bad++; $display("FAIL sat_data[%0d]: got %h want %h (timeout=%b)", r, bus.out_data, exp_d[r], any_to); end
      n_cmp++; if (bus.sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag[%0d]: got %b want 1", r, bus.sat); end
      finish_out();
    end
  endtask

  task automatic test_rounding();
    bit t0, t1;
    int n;
    logic [31:0] xv [2];
    logic [31:0] exp_d [2];
    xv[0] = 32'h0000_0001; exp_d[0] = 32'h0000_0001;
    xv[1] = 32'hFFFF_FFFF; exp_d[1] = 32'h0000_0000;
    for (int r = 0; r < 2; r++) begin
      start_op(8'd1, 32'h0);
      feed(xv[r], 32'h0000_8000, t0);
      wait_out(n, t1);
      n_cmp++; if (t0 || t1 || bus.out_data !== exp_d[r] || bus.sat !== 1'b0) begin n_bad++; $display("FAIL round[%0d]: got %h sat=%b want %h sat=0 (timeout=%b)", r, bus.out_data, bus.sat, exp_d[r], t0 | t1); end
      finish_out();
    end
  endtask

  task automatic test_zero_len();
    bit to;
    int n;
    start_op(8'd0, 32'hFFFF_8000);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_in_ready: got %b want 0", bus.in_ready); end
    wait_out(n, to);
    n_cmp++; if (to || n !== 1) begin n_bad++; $display("FAIL zero_latency: got %0d want 1 (timeout=%b)", n, to); end
    n_cmp++; if (bus.out_data !== 32'hFFFF_8000 || bus.sat !== 1'b0) begin n_bad++; $display("FAIL zero_data: got %h sat=%b want ffff8000 sat=0", bus.out_data, bus.sat); end
    finish_out();
  endtask

  task automatic test_gaps_backpressure();
    bit to;
    int n, k;
    logic pat [6];
    logic [31:0] xv [3];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    xv  = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    k = 0;
    start_op(8'd3, 32'h0);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = pat[i];
      bus.x = (k < 3) ? xv[k] : 32'h0;
      bus.w = 32'h0001_0000;
      if (bus.in_valid && bus.in_ready) k++;
      cyc();
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL gap_beats: got %0d want 3", k); end
    wait_out(n, to);
    n_cmp++; if (to || bus.out_data !== 32'h0006_0000) begin n_bad++; $display("FAIL gap_data: got %h want 00060000 (timeout=%b)", bus.out_data, to); end
    for (int c = 0; c < 5; c++) begin
      bus.start = (c == 2); bus.len = 8'd0; bus.bias = 32'h1234_0000;
      cyc();
      bus.start = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0006_0000 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL hold[%0d]: got valid=%b data=%h busy=%b want 1 00060000 1", c, bus.out_valid, bus.out_data, bus.busy); end
    end
    finish_out();
    n_cmp++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got busy=%b valid=%b want 0 0", bus.busy, bus.out_valid); end
    cyc();
    n_cmp++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0006_0000) begin n_bad++; $display("FAIL bp_start_ignored: got busy=%b valid=%b data=%h want 0 0 00060000", bus.busy, bus.out_valid, bus.out_data); end
  endtask

  task automatic test_reset_mid();
    bit t0, t1, t2;
    int n;
    start_op(8'd4, 32'h0005_0000);
    feed(32'h0001_0000, 32'h0001_0000, t0);
    feed(32'h0001_0000, 32'h0001_0000, t1);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctl: got rdy=%b busy=%b valid=%b want 0 0 0", bus.in_ready, bus.busy, bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'h0 || bus.sat !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out: got %h sat=%b want 0 0", bus.out_data, bus.sat); end
    cyc();
    rst = 1'b0;
    cyc();
    start_op(8'd1, 32'h0);
    feed(32'h0001_0000, 32'h0001_0000, t2);
    wait_out(n, t0);
    n_cmp++; if (t0 || t1 || t2 || bus.out_data !== 32'h0001_0000 || bus.sat !== 1'b0) begin n_bad++; $display("FAIL mid_rst_new: got %h sat=%b want 00010000 sat=0 (timeout=%b)", bus.out_data, bus.sat, t0 | t1 | t2); end
    finish_out();
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.bias = '0;
    bus.in_valid = 1'b0; bus.x = '0; bus.w = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_zero_len();
    test_gaps_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
